data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder.sv | 106 ++++++++++
 tb/tb_data_mem_responder.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// MEM-stage data memory: fixed LATENCY-cycle access with a one-cycle ack pulse.
// stall_o freezes the pipeline from request until ack; DMEM_ALIGN_CHECK_EN enables misalignment errors.
module data_mem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        stall_o,
    output logic        ack_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);
    localparam int IW = $clog2(DEPTH);
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic        lat_we;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [31:0] mem [DEPTH];

    logic          acc_we;
    logic [31:0]   acc_addr;
    logic [31:0]   acc_wdata;
    logic [IW-1:0] acc_idx;
    logic          enter_resp;
    logic          misalign;
    logic          unused_bits;

    // With LATENCY=1 the access completes on the accept edge, so use the live inputs.
    always_comb begin
        acc_we    = lat_we;
        acc_addr  = lat_addr;
        acc_wdata = lat_wdata;
        if (state == IDLE) begin
            acc_we    = we_i;
            acc_addr  = addr_i;
            acc_wdata = wdata_i;
        end
    end

    assign acc_idx    = acc_addr[IW+1:2];
    assign enter_resp = ((state == IDLE) && req_i && (LATENCY == 1)) ||
                        ((state == WAIT) && (cnt == 4'd1));
    assign stall_o    = ((state == IDLE) && req_i) || (state == WAIT);

`ifdef DMEM_ALIGN_CHECK_EN
    assign misalign    = (acc_addr[1:0] != 2'b00);
    assign unused_bits = ^acc_addr[31:IW+2];
`else
    assign misalign    = 1'b0;
    assign unused_bits = ^{acc_addr[31:IW+2], acc_addr[1:0]};
`endif

    // Memory is written only outside reset and is never cleared by it.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            lat_we    <= 1'b0;
            lat_addr  <= 32'd0;
            lat_wdata <= 32'd0;
            ack_o     <= 1'b0;
            rdata_o   <= 32'd0;
            err_o     <= 1'b0;
        end else begin
            ack_o   <= 1'b0;
            rdata_o <= 32'd0;
            err_o   <= 1'b0;
            if (enter_resp) begin
                ack_o <= 1'b1;
                err_o <= misalign;
                if (!acc_we && !misalign)
                    rdata_o <= mem[acc_idx];
                if (acc_we && !misalign)
                    mem[acc_idx] <= acc_wdata;
            end
            case (state)
                IDLE: begin
                    if (req_i) begin
                        lat_we    <= we_i;
                        lat_addr  <= addr_i;
                        lat_wdata <= wdata_i;
                        cnt       <= CNT_INIT;
                        state     <= (LATENCY == 1) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1)
                        state <= RESP;
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: scoreboarded LATENCY=4 accesses plus a LATENCY=1 instance.
// Expected load data, error flag and ack cycle are queued at request time and checked on ack.
`timescale 1ns/1ps
module tb_data_mem_responder;
    localparam int LAT = 4;
`ifdef DMEM_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    typedef struct {
        logic [31:0] rd;
        logic        err;
        logic [31:0] cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req, we, stall, ack, err;
    logic [31:0] addr, wdata, rdata;
    logic        req1, we1, stall1, ack1, err1;
    logic [31:0] addr1, wdata1, rdata1;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] cyc = 32'd0;
    exp_t        sb[$];

    data_mem_responder #(.DEPTH(256), .LATENCY(LAT)) u_dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr),
        .wdata_i(wdata), .stall_o(stall), .ack_o(ack), .rdata_o(rdata), .err_o(err)
    );

    data_mem_responder #(.DEPTH(256), .LATENCY(1)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .req_i(req1), .we_i(we1), .addr_i(addr1),
        .wdata_i(wdata1), .stall_o(stall1), .ack_o(ack1), .rdata_o(rdata1), .err_o(err1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 32'd1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    // Scoreboard consumer: every ack must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (ack) begin
            if (sb.size() == 0) begin
                check("unexpected_ack", {31'd0, ack}, 32'd0);
            end else begin
                e = sb.pop_front();
                check("rdata", rdata, e.rd);
                check("err", {31'd0, err}, {31'd0, e.err});
                check("ack_cycle", cyc, e.cyc);
            end
        end else begin
            check("rdata_zero_no_ack", rdata, 32'd0);
        end
    end

    task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] exp_rd, input logic exp_err);
        exp_t e;
        bit   done;
        done = 1'b0;
        @(negedge clk);
        req = 1'b1; we = w; addr = a; wdata = d;
        #1 check("stall_idle_req", {31'd0, stall}, 32'd1);
        e.rd = exp_rd; e.err = exp_err; e.cyc = cyc + LAT;
        sb.push_back(e);
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (ack) begin
                check("stall_resp", {31'd0, stall}, 32'd0);
                req  = 1'b0;
                done = 1'b1;
            end else begin
                check("stall_wait", {31'd0, stall}, 32'd1);
                addr  = $urandom;
                wdata = $urandom;
            end
        end
        if (!done) begin
            check("ack_timeout", {31'd0, ack}, 32'd1);
            req = 1'b0;
            sb.delete();
        end
        @(negedge clk);
        check("stall_idle", {31'd0, stall}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at time %0t, expected completion", $time);
        $fatal(1);
    end

    initial begin
        req = 1'b0; we = 1'b0; addr = 32'd0; wdata = 32'd0;
        req1 = 1'b0; we1 = 1'b0; addr1 = 32'd0; wdata1 = 32'd0;
        #1 rst = 1'b0;
        #1;
        check("rst_ack", {31'd0, ack}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_stall_noreq", {31'd0, stall}, 32'd0);
        req = 1'b1;
        #1 check("rst_stall_req", {31'd0, stall}, 32'd1);
        req = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst = 1'b1;

        // Store/load, wrap-around and top-of-memory boundary
        access(1'b1, 32'h10, 32'hDEADBEEF, 32'd0, 1'b0);
        access(1'b0, 32'h10, 32'd0, 32'hDEADBEEF, 1'b0);
        access(1'b1, 32'h400, 32'h1234, 32'd0, 1'b0);
        access(1'b0, 32'h0, 32'd0, 32'h1234, 1'b0);
        access(1'b1, 32'h3FC, 32'hCAFE_F00D, 32'd0, 1'b0);
        access(1'b0, 32'hFFFF_FFFC, 32'd0, 32'hCAFE_F00D, 1'b0);
        access(1'b0, 32'h10, 32'd0, 32'hDEADBEEF, 1'b0);

        // Reset during WAIT aborts a pending store
        access(1'b1, 32'h20, 32'h1111, 32'd0, 1'b0);
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'hAAAA;
        @(negedge clk);
        #1 check("stall_wait_pre_rst", {31'd0, stall}, 32'd1);
        @(negedge clk);
        #2 req = 1'b0; rst = 1'b0;
        #1;
        check("abort_stall", {31'd0, stall}, 32'd0);
        check("abort_ack", {31'd0, ack}, 32'd0);
        check("abort_err", {31'd0, err}, 32'd0);
        #3 rst = 1'b1;
        access(1'b0, 32'h20, 32'd0, 32'h1111, 1'b0);

        // Misaligned store and load
        access(1'b1, 32'h22, 32'h77, 32'd0, ALIGN);
        access(1'b0, 32'h20, 32'd0, ALIGN ? 32'h1111 : 32'h77, 1'b0);
        access(1'b0, 32'h23, 32'd0, ALIGN ? 32'h0 : 32'h77, ALIGN);

        // LATENCY=1 instance: req held across a store then a load
        @(negedge clk);
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'd0; wdata1 = 32'h5;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("l1_ack", {31'd0, ack1}, (i % 2 == 0) ? 32'd1 : 32'd0);
            check("l1_stall", {31'd0, stall1}, (i == 1) ? 32'd1 : 32'd0);
            check("l1_rdata", rdata1, (i == 2) ? 32'h5 : 32'h0);
            check("l1_err", {31'd0, err1}, 32'd0);
            if (i == 0) begin
                we1 = 1'b0;
                wdata1 = 32'hFFFF_FFFF;
            end
            if (i == 2) req1 = 1'b0;
        end

        repeat (3) @(negedge clk);
        check("sb_empty", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
